// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  // Controller modes: normal flow, waiting on the mult/div unit, halted by syscall
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_WAIT = 2'b01,
    HALT    = 2'b10
  } ctrl_state_t;

  localparam int REG_IDX_W = 5;
  localparam int JUMP_W    = 2;

  localparam logic [JUMP_W-1:0] JUMP_NONE = 2'b00;
  localparam logic [5:0]        OPC_LW    = 6'b100011;

  // A load in EX feeds a register the ID instruction really reads; $zero never hazards
  function automatic logic isLoadUse(
    input logic                 memRead,
    input logic [REG_IDX_W-1:0] writeNum,
    input logic                 readEn1,
    input logic [REG_IDX_W-1:0] readNum1,
    input logic                 readEn2,
    input logic [REG_IDX_W-1:0] readNum2
  );
    return memRead && (writeNum != '0) &&
           ((readEn1 && (readNum1 == writeNum)) ||
            (readEn2 && (readNum2 == writeNum)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs and pipeline control outputs of the sequencing controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] regfile_read_num1_if_id;
  logic [REG_IDX_W-1:0] regfile_read_num2_if_id;
  logic                 read_en1_if_id;
  logic                 read_en2_if_id;
  logic                 mem_read_id_ex;
  logic [REG_IDX_W-1:0] regfile_write_num_id_ex;
  logic                 branch_taken_ex;
  logic [JUMP_W-1:0]    Jump_id_ex;
  logic                 md_start_id_ex;
  logic                 md_done;
  logic                 syscall_halt_mem;
  logic                 resume;

  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_flush;
  logic                 id_ex_en;
  logic                 id_ex_flush;
  logic                 ex_mem_flush;
  logic                 halted;
  logic                 md_error;
  logic [CNT_W-1:0]     stall_count;

  // Pipeline side: drives the hazard inputs, observes the control lines
  modport master (
    output regfile_read_num1_if_id, regfile_read_num2_if_id,
           read_en1_if_id, read_en2_if_id, mem_read_id_ex,
           regfile_write_num_id_ex, branch_taken_ex, Jump_id_ex,
           md_start_id_ex, md_done, syscall_halt_mem, resume,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_flush, halted, md_error, stall_count
  );

  // Controller side
  modport slave (
    input  regfile_read_num1_if_id, regfile_read_num2_if_id,
           read_en1_if_id, read_en2_if_id, mem_read_id_ex,
           regfile_write_num_id_ex, branch_taken_ex, Jump_id_ex,
           md_start_id_ex, md_done, syscall_halt_mem, resume,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_flush, halted, md_error, stall_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Advance only while enabled and not yet at the ceiling
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubble, redirect flush,
// mult/div wait with timeout, and syscall halt/resume.
module hazard_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);

  // Ten bits cover the largest legal timeout of 1023
  localparam int                 TIMER_W     = 10;
  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(MD_TIMEOUT);

  ctrl_state_t        state_q;
  ctrl_state_t        state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic               mdErr_q;
  logic               mdErr_d;

  logic loadUse;
  logic redirect;
  logic stallAll;
  logic applyHazards;
  logic pcEn;
  logic ifIdEn;
  logic ifIdFlush;
  logic idExEn;
  logic idExFlush;
  logic exMemFlush;
  logic haltedOut;
  logic stallEn;
  logic [CNT_W-1:0] stallCount;

  // Hazards that forwarding cannot resolve
  always_comb begin
    loadUse  = isLoadUse(bus.mem_read_id_ex, bus.regfile_write_num_id_ex,
                         bus.read_en1_if_id, bus.regfile_read_num1_if_id,
                         bus.read_en2_if_id, bus.regfile_read_num2_if_id);
    redirect = bus.branch_taken_ex || (bus.Jump_id_ex != JUMP_NONE);
  end

  // Next state, timer, sticky error and the pipeline control lines
  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    mdErr_d      = mdErr_q;
    stallAll     = 1'b0;
    applyHazards = 1'b0;
    pcEn         = 1'b1;
    ifIdEn       = 1'b1;
    idExEn       = 1'b1;
    ifIdFlush    = 1'b0;
    idExFlush    = 1'b0;
    exMemFlush   = 1'b0;
    haltedOut    = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.syscall_halt_mem) begin
          stallAll = 1'b1;
          state_d  = HALT;
        end else if (bus.md_start_id_ex && !bus.md_done) begin
          stallAll = 1'b1;
          state_d  = MD_WAIT;
          timer_d  = TIMER_W'(1);
        end else begin
          applyHazards = 1'b1;
        end
      end

      MD_WAIT: begin
        // A late timeout is still recorded even when a syscall wins the transition
        if ((timer_q == TIMEOUT_VAL) && !bus.md_done) begin
          mdErr_d = 1'b1;
        end
        if (bus.syscall_halt_mem) begin
          stallAll = 1'b1;
          state_d  = HALT;
        end else if (bus.md_done) begin
          applyHazards = 1'b1;
          state_d      = RUN;
        end else if (timer_q == TIMEOUT_VAL) begin
          stallAll = 1'b1;
          state_d  = RUN;
        end else begin
          stallAll = 1'b1;
          timer_d  = timer_q + TIMER_W'(1);
        end
      end

      HALT: begin
        pcEn      = 1'b0;
        ifIdEn    = 1'b0;
        idExEn    = 1'b0;
        haltedOut = 1'b1;
        if (bus.resume) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (stallAll) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idExEn     = 1'b0;
      exMemFlush = 1'b1;
    end

    // A redirect squashes the wrong-path instruction, so its load-use stall is moot
    if (applyHazards) begin
      if (redirect) begin
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
      end else if (loadUse) begin
        pcEn      = 1'b0;
        ifIdEn    = 1'b0;
        idExFlush = 1'b1;
      end
    end

    // While reset is held the pipeline is frozen with every register cleared
    if (!rst_n) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idExEn     = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      exMemFlush = 1'b1;
      haltedOut  = 1'b0;
    end
  end

  // Controller state, mult/div timer and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      timer_q <= '0;
      mdErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mdErr_q <= mdErr_d;
    end
  end

  // Halted cycles are deliberate, not stalls, so they are not counted
  always_comb begin
    stallEn = rst_n && !pcEn && (state_q != HALT);
  end

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (stallEn),
    .count_o (stallCount)
  );

  // Drive the interface outputs
  always_comb begin
    bus.pc_en        = pcEn;
    bus.if_id_en     = ifIdEn;
    bus.if_id_flush  = ifIdFlush;
    bus.id_ex_en     = idExEn;
    bus.id_ex_flush  = idExFlush;
    bus.ex_mem_flush = exMemFlush;
    bus.halted       = haltedOut;
    bus.md_error     = mdErr_q;
    bus.stall_count  = stallCount;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit in the ID/EX boundary logic.
- Resolves hazards forwarding cannot cover:
  - load-use stall (one bubble)
  - branch/jump redirect flush
  - multi-cycle mult/div wait, with timeout
  - syscall halt/resume
- Drives the PC enable and the pipeline-register enable/flush lines, and keeps a saturating stall-cycle counter.

Parameters:
MD_TIMEOUT, 64, maximum MD_WAIT cycles before forced exit; legal range 2..1023.
CNT_W, 32, width of stall_count.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous assert, active-low
regfile_read_num1_if_id  in  5  rs index of instruction in ID
regfile_read_num2_if_id  in  5  rt index of instruction in ID
read_en1_if_id  in  1  ID instruction really reads rs
read_en2_if_id  in  1  ID instruction really reads rt
mem_read_id_ex  in  1  EX instruction is a load
regfile_write_num_id_ex  in  5  destination register of EX instruction
branch_taken_ex  in  1  branch resolved taken in EX
Jump_id_ex  in  2  jump class of EX instruction; 00 = none, any other value = redirect
md_start_id_ex  in  1  EX instruction is mult/div
md_done  in  1  mult/div result valid this cycle
syscall_halt_mem  in  1  halting syscall in MEM
resume  in  1  single-cycle pulse to leave HALT
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear (bubble)
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX clear
ex_mem_flush  out  1  EX/MEM clear
halted  out  1  core halted
md_error  out  1  sticky: mult/div timeout occurred
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
Reset (rst_n low), asynchronous:
- State = RUN; timer = 0; stall_count = 0; md_error = 0.
- pc_en = if_id_en = id_ex_en = 0.
- if_id_flush = id_ex_flush = ex_mem_flush = 1.
- halted = 0.

States:
- RUN, MD_WAIT, HALT (enum in package). Outputs are combinational from state + inputs; state, timer and counters are registered.

Hazard definitions:
- load_use = mem_read_id_ex && regfile_write_num_id_ex != 0 && ((read_en1_if_id && rs == wn) || (read_en2_if_id && rt == wn)).
- redirect = branch_taken_ex || Jump_id_ex != 2'b00.

RUN, default outputs: all enables 1, all flushes 0. Priority, high to low:
1. syscall_halt_mem:
   - pc_en = if_id_en = id_ex_en = 0; ex_mem_flush = 1.
   - Next state HALT.
2. md_start_id_ex && !md_done:
   - pc_en = if_id_en = id_ex_en = 0; ex_mem_flush = 1.
   - Next state MD_WAIT; timer <= 1.
3. redirect:
   - if_id_flush = 1, id_ex_flush = 1; pc_en = 1.
   - Overrides load_use, since the stalled instruction is wrong-path.
4. load_use:
   - pc_en = 0, if_id_en = 0, id_ex_flush = 1.
   - Exactly one bubble, because the load advances next cycle.
- md_start_id_ex with md_done in the same cycle is treated as a normal RUN cycle.

MD_WAIT:
- Outputs as in RUN priority 2; timer increments each cycle.
- syscall_halt_mem: next state HALT; takes priority over md_done.
- md_done: this cycle behaves exactly as RUN, applying rules 3–4 to the current inputs; next state RUN.
- timer == MD_TIMEOUT without md_done: md_error <= 1; next state RUN (the instruction advances with a garbage result).

HALT:
- All enables 0, all flushes 0; halted = 1.
- resume: next state RUN. resume in any other state is ignored.

stall_count:
- Increments on every cycle with rst_n high, pc_en == 0 and state != HALT.
- Holds at all-ones (saturates, no wrap).
- Not reset by resume.

Reset mid-operation (including in MD_WAIT or HALT) returns immediately to the reset values.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state enum ctrl_state_t {RUN, MD_WAIT, HALT}
  - Jump encoding constants (JUMP_NONE = 2'b00)
  - OPC_LW = 6'b100011
  - the hazard-input field widths (register index = 5)
- One sub-module, sat_counter #(W): enable input, asynchronous active-low clear, holds at max. Used for stall_count.
- The timer stays inline.

Test Plan:
- lw $3 in EX (mem_read_id_ex=1, wn=3), ID reads rs=3 with read_en1=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_count 0→1.
- Same load-use plus branch_taken_ex=1 -> no stall; if_id_flush=id_ex_flush=1, pc_en=1; stall_count unchanged. Repeat with wn=0 -> no stall.
- md_start_id_ex=1, md_done after 5 cycles -> 5 cycles with pc_en=0, ex_mem_flush=1; the md_done cycle has all enables 1; state back to RUN; stall_count=5.
- MD_TIMEOUT=8, md_done never asserted -> md_error rises after 8 stalled cycles, state RUN, md_error stays 1 until reset.
- syscall_halt_mem=1 during MD_WAIT -> halted=1 next cycle, all enables 0, stall_count frozen; resume pulse -> RUN, pc_en=1. Assert rst_n=0 while halted -> immediate reset values.
- CNT_W=4, force 20 load-use stalls -> stall_count saturates at 15.
